// File: rtl/regfile_wb_pkg.sv
// Shared widths and types for the register-file writeback arbiter.
// Optional scoreboard in the top is enabled by macro REGFILE_WB_SCOREBOARD_EN.
package regfile_wb_pkg;
    localparam int AW   = 5;
    localparam int DW   = 32;
    localparam int NREG = 2 ** AW;
    localparam int IDW  = 3;

    localparam logic [AW-1:0] REG_ZERO = '0;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } wb_req_t;
endpackage

// File: rtl/regfile_wb_arbiter_rr_arbiter.sv
// Round-robin arbiter: one-hot grant to the first request at or after the pointer.
// The pointer moves past the granted index and holds when nothing is granted.
module rr_arbiter
    import regfile_wb_pkg::*;
#(
    parameter int N = 3
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           en,
    input  logic [N-1:0]   req,
    output logic [N-1:0]   gnt,
    output logic [IDW-1:0] gnt_idx
);
    logic [IDW-1:0] ptr_q, ptr_d;
    logic           found;

    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        found   = 1'b0;
        for (int k = 0; k < N; k++) begin
            int i;
            i = int'(ptr_q) + k;
            if (i >= N) i = i - N;
            if (en && !found && req[i]) begin
                gnt[i]  = 1'b1;
                gnt_idx = IDW'(i);
                found   = 1'b1;
            end
        end
    end

    always_comb begin
        ptr_d = ptr_q;
        if (found) begin
            ptr_d = (int'(gnt_idx) == N - 1) ? '0 : gnt_idx + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end
endmodule

// File: rtl/regfile_wb_arbiter.sv
// Shares the regfile write port among NREQ writeback sources with registered outputs.
// Busy-bit scoreboard is built only when REGFILE_WB_SCOREBOARD_EN is defined.
module regfile_wb_arbiter
    import regfile_wb_pkg::*;
#(
    parameter int NREQ = 3,
    parameter int DW   = regfile_wb_pkg::DW,
    parameter int AW   = regfile_wb_pkg::AW
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      req_valid,
    output logic [NREQ-1:0]      req_ready,
    input  logic [NREQ*AW-1:0]   req_addr,
    input  logic [NREQ*DW-1:0]   req_data,
    input  logic                 wb_stall,
    output logic                 writeReg,
    output logic [AW-1:0]        wa,
    output logic [DW-1:0]        wd,
    output logic [2:0]           grant_id,
    input  logic                 rsv_valid,
    input  logic [AW-1:0]        rsv_addr,
    output logic [2**AW-1:0]     busy
);
    logic [NREQ-1:0] gnt;
    logic [IDW-1:0]  gnt_idx;
    logic            hs;
    logic            wr;
    wb_req_t         sel;

    logic            write_q;
    wb_req_t         out_q;
    logic [2:0]      gid_q;

    // Grants are suppressed during reset so no source sees a stray accept.
    rr_arbiter #(.N(NREQ)) u_rr (
        .clk     (clk),
        .rst     (rst),
        .en      (!wb_stall && !rst),
        .req     (req_valid),
        .gnt     (gnt),
        .gnt_idx (gnt_idx)
    );

    assign req_ready = gnt;
    assign hs        = |gnt;

    always_comb begin
        sel      = '0;
        sel.addr = req_addr[int'(gnt_idx)*AW +: AW];
        sel.data = req_data[int'(gnt_idx)*DW +: DW];
    end

    // Writes to $0 are accepted but never reach the port.
    assign wr = hs && (sel.addr != REG_ZERO);

    always_ff @(posedge clk) begin
        if (rst) begin
            write_q <= 1'b0;
            out_q   <= '0;
            gid_q   <= '0;
        end else begin
            write_q <= wr;
            if (wr) begin
                out_q <= sel;
                gid_q <= gnt_idx;
            end
        end
    end

    assign writeReg = write_q;
    assign wa       = out_q.addr;
    assign wd       = out_q.data;
    assign grant_id = gid_q;

`ifdef REGFILE_WB_SCOREBOARD_EN
    logic [2**AW-1:0] busy_q, busy_d, set_mask, clr_mask;

    // Set is applied after clear so a fresh reservation outlives an older write.
    always_comb begin
        set_mask = '0;
        clr_mask = '0;
        if (rsv_valid && (rsv_addr != REG_ZERO)) set_mask[rsv_addr] = 1'b1;
        if (wr) clr_mask[sel.addr] = 1'b1;
        busy_d    = (busy_q & ~clr_mask) | set_mask;
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    assign busy = busy_q;
`else
    logic unused_rsv;
    assign unused_rsv = ^{rsv_valid, rsv_addr};
    assign busy       = '0;
`endif
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter (NREQ=3); scoreboard checks follow REGFILE_WB_SCOREBOARD_EN.
module tb_regfile_wb_arbiter;
    localparam int NREQ = 3;
    localparam int AW   = 5;
    localparam int DW   = 32;

    logic              clk = 1'b0;
    logic              rst;
    logic [NREQ-1:0]   req_valid;
    logic [NREQ-1:0]   req_ready;
    logic [NREQ*AW-1:0] req_addr;
    logic [NREQ*DW-1:0] req_data;
    logic              wb_stall;
    logic              writeReg;
    logic [AW-1:0]     wa;
    logic [DW-1:0]     wd;
    logic [2:0]        grant_id;
    logic              rsv_valid;
    logic [AW-1:0]     rsv_addr;
    logic [2**AW-1:0]  busy;

    int n_cmp = 0;
    int n_bad = 0;

    logic [DW-1:0] dat [NREQ] = '{32'h1111_0000, 32'h2222_0001, 32'h3333_0002};

    regfile_wb_arbiter #(.NREQ(NREQ), .DW(DW), .AW(AW)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_addr  (req_addr),
        .req_data  (req_data),
        .wb_stall  (wb_stall),
        .writeReg  (writeReg),
        .wa        (wa),
        .wd        (wd),
        .grant_id  (grant_id),
        .rsv_valid (rsv_valid),
        .rsv_addr  (rsv_addr),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_all_valid();
        req_valid = 3'b111;
        req_addr  = {5'd3, 5'd2, 5'd1};
        req_data  = {dat[2], dat[1], dat[0]};
    endtask

    task automatic test_reset();
        rst = 1'b1;
        wb_stall = 1'b0;
        rsv_valid = 1'b0;
        rsv_addr = '0;
        set_all_valid();
        tick();
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            n_cmp++;
            if (req_ready !== 3'b000) begin
                n_bad++; $display("FAIL reset_ready: got %b want 000", req_ready);
            end
            n_cmp++;
            if (writeReg !== 1'b0 || wa !== '0 || wd !== '0 || grant_id !== 3'd0) begin
                n_bad++; $display("FAIL reset_outputs: got we=%b wa=%0d wd=%h gid=%0d want 0/0/0/0", writeReg, wa, wd, grant_id);
            end
            n_cmp++;
            if (busy !== '0) begin
                n_bad++; $display("FAIL reset_busy: got %h want 0", busy);
            end
            tick();
        end
        rst = 1'b0;
    endtask

    // All three sources valid for six grant cycles starting at pointer 'start'.
    task automatic test_fairness(input int start);
        int g;
        int prev;
        set_all_valid();
        prev = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            g = (start + c) % NREQ;
            n_cmp++;
            if (req_ready !== 3'(1 << g)) begin
                n_bad++; $display("FAIL fair_ready[%0d]: got %b want %b", c, req_ready, 3'(1 << g));
            end
            if (c > 0) begin
                n_cmp++;
                if (writeReg !== 1'b1 || wa !== 5'(prev + 1) || wd !== dat[prev] || grant_id !== 3'(prev)) begin
                    n_bad++; $display("FAIL fair_write[%0d]: got we=%b wa=%0d wd=%h gid=%0d want 1/%0d/%h/%0d",
                                      c, writeReg, wa, wd, grant_id, prev + 1, dat[prev], prev);
                end
            end
            prev = g;
            tick();
        end
        req_valid = '0;
        @(negedge clk);
        n_cmp++;
        if (req_ready !== 3'b000 || writeReg !== 1'b1 || wa !== 5'(prev + 1)) begin
            n_bad++; $display("FAIL fair_last: got rdy=%b we=%b wa=%0d want 000/1/%0d", req_ready, writeReg, wa, prev + 1);
        end
        tick();
        @(negedge clk);
        n_cmp++;
        if (writeReg !== 1'b0) begin
            n_bad++; $display("FAIL fair_idle: got we=%b want 0", writeReg);
        end
        tick();
    endtask

    // Pointer 0 on entry; leaves pointer at 2.
    task automatic test_zero_reg();
        req_valid = 3'b001;
        req_addr  = {5'd0, 5'd0, 5'd0};
        req_data  = {32'h0, 32'h0, 32'hDEAD_BEEF};
        @(negedge clk);
        n_cmp++;
        if (req_ready !== 3'b001) begin
            n_bad++; $display("FAIL zero_ready: got %b want 001", req_ready);
        end
        tick();
        req_valid = 3'b011;
        req_addr  = {5'd0, 5'd2, 5'd1};
        req_data  = {32'h0, 32'h0000_0022, 32'h0000_0011};
        @(negedge clk);
        n_cmp++;
        if (writeReg !== 1'b0) begin
            n_bad++; $display("FAIL zero_nowrite: got we=%b want 0", writeReg);
        end
        n_cmp++;
        if (req_ready !== 3'b010) begin
            n_bad++; $display("FAIL zero_ptr_adv: got %b want 010", req_ready);
        end
        tick();
        req_valid = '0;
        @(negedge clk);
        n_cmp++;
        if (writeReg !== 1'b1 || wa !== 5'd2 || wd !== 32'h22 || grant_id !== 3'd1) begin
            n_bad++; $display("FAIL zero_next_write: got we=%b wa=%0d wd=%h gid=%0d want 1/2/22/1", writeReg, wa, wd, grant_id);
        end
        tick();
    endtask

    // Pointer 2 on entry; only req1 valid so the grant wraps; leaves pointer at 2.
    task automatic test_stall();
        wb_stall  = 1'b1;
        req_valid = 3'b010;
        req_addr  = {5'd0, 5'd4, 5'd0};
        req_data  = {32'h0, 32'h0000_0044, 32'h0};
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            n_cmp++;
            if (req_ready !== 3'b000 || writeReg !== 1'b0) begin
                n_bad++; $display("FAIL stall_hold[%0d]: got rdy=%b we=%b want 000/0", c, req_ready, writeReg);
            end
            tick();
        end
        wb_stall = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (req_ready !== 3'b010) begin
            n_bad++; $display("FAIL stall_release_ready: got %b want 010", req_ready);
        end
        tick();
        req_valid = '0;
        @(negedge clk);
        n_cmp++;
        if (writeReg !== 1'b1 || wa !== 5'd4 || wd !== 32'h44 || grant_id !== 3'd1) begin
            n_bad++; $display("FAIL stall_write: got we=%b wa=%0d wd=%h gid=%0d want 1/4/44/1", writeReg, wa, wd, grant_id);
        end
        tick();
    endtask

`ifdef REGFILE_WB_SCOREBOARD_EN
    // Pointer 2 on entry; req0 granted twice, leaves pointer at 1.
    task automatic test_scoreboard();
        rsv_valid = 1'b1;
        rsv_addr  = 5'd5;
        tick();
        rsv_valid = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (busy !== 32'h0000_0020) begin
            n_bad++; $display("FAIL sb_set: got %h want 00000020", busy);
        end
        rsv_valid = 1'b1;
        rsv_addr  = 5'd5;
        req_valid = 3'b001;
        req_addr  = {5'd0, 5'd0, 5'd5};
        req_data  = {32'h0, 32'h0, 32'h0000_0055};
        tick();
        rsv_valid = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (busy !== 32'h0000_0020) begin
            n_bad++; $display("FAIL sb_set_wins: got %h want 00000020", busy);
        end
        n_cmp++;
        if (writeReg !== 1'b1 || wa !== 5'd5) begin
            n_bad++; $display("FAIL sb_write1: got we=%b wa=%0d want 1/5", writeReg, wa);
        end
        tick();
        req_valid = '0;
        rsv_valid = 1'b1;
        rsv_addr  = 5'd0;
        @(negedge clk);
        n_cmp++;
        if (busy !== 32'h0000_0000) begin
            n_bad++; $display("FAIL sb_clear: got %h want 00000000", busy);
        end
        tick();
        rsv_valid = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (busy !== 32'h0000_0000) begin
            n_bad++; $display("FAIL sb_zero_ignored: got %h want 00000000", busy);
        end
        tick();
    endtask
`else
    task automatic test_scoreboard_off();
        for (int c = 0; c < 3; c++) begin
            rsv_valid = (c != 1);
            rsv_addr  = 5'd7;
            tick();
            @(negedge clk);
            n_cmp++;
            if (busy !== '0) begin
                n_bad++; $display("FAIL sb_off_busy[%0d]: got %h want 0", c, busy);
            end
        end
        rsv_valid = 1'b0;
        tick();
    endtask
`endif

    initial begin
        test_reset();
        test_fairness(0);
        test_zero_reg();
        test_stall();
`ifdef REGFILE_WB_SCOREBOARD_EN
        test_scoreboard();
        test_fairness(1);
`else
        test_scoreboard_off();
        test_fairness(2);
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
